// File: rtl/cpu_pkg.sv
// Shared CPU definitions: fetch FSM states, opcode constants, IF/ID payload.
package cpu_pkg;

  localparam int unsigned XLEN = 16;
  localparam int unsigned OPW  = 4;

  localparam logic [XLEN-1:0] RESET_PC_DEF = 16'h0000;

  localparam logic [OPW-1:0] OP_HALT = 4'hF;
  localparam logic [OPW-1:0] OP_B    = 4'hC;
  localparam logic [OPW-1:0] OP_BR   = 4'hD;

  typedef enum logic [1:0] {
    ST_FETCH = 2'd0,
    ST_WAIT  = 2'd1,
    ST_DROP  = 2'd2,
    ST_HALT  = 2'd3
  } fetch_state_t;

  typedef struct packed {
    logic [XLEN-1:0] instr;
    logic [XLEN-1:0] pc;
  } ifid_t;

endpackage

// File: rtl/CLA_16bit.sv
// 16-bit carry-lookahead adder: four 4-bit lookahead groups with a lookahead carry chain between them.
module CLA_16bit (
  input  logic [15:0] a,
  input  logic [15:0] b,
  input  logic        cin,
  output logic [15:0] sum
);

  function automatic logic [3:0] grp_carry(input logic [3:0] g, input logic [3:0] p, input logic ci);
    logic [3:0] c;
    c[0] = ci;
    c[1] = g[0] | (p[0] & ci);
    c[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & ci);
    c[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0]) | (p[2] & p[1] & p[0] & ci);
    return c;
  endfunction

  function automatic logic grp_gen(input logic [3:0] g, input logic [3:0] p);
    return g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1]) | (p[3] & p[2] & p[1] & g[0]);
  endfunction

  logic [15:0] g;
  logic [15:0] p;
  logic [15:0] c;
  logic [2:0]  gg;
  logic [2:0]  gp;
  logic        c4;
  logic        c8;
  logic        c12;

  assign g = a & b;
  assign p = a ^ b;

  assign gg[0] = grp_gen(g[3:0],  p[3:0]);
  assign gg[1] = grp_gen(g[7:4],  p[7:4]);
  assign gg[2] = grp_gen(g[11:8], p[11:8]);
  assign gp[0] = &p[3:0];
  assign gp[1] = &p[7:4];
  assign gp[2] = &p[11:8];

  // Group carries fully expanded so no carry depends on another group's ripple.
  assign c4  = gg[0] | (gp[0] & cin);
  assign c8  = gg[1] | (gp[1] & gg[0]) | (gp[1] & gp[0] & cin);
  assign c12 = gg[2] | (gp[2] & gg[1]) | (gp[2] & gp[1] & gg[0]) | (gp[2] & gp[1] & gp[0] & cin);

  assign c[3:0]   = grp_carry(g[3:0],   p[3:0],   cin);
  assign c[7:4]   = grp_carry(g[7:4],   p[7:4],   c4);
  assign c[11:8]  = grp_carry(g[11:8],  p[11:8],  c8);
  assign c[15:12] = grp_carry(g[15:12], p[15:12], c12);

  assign sum = p ^ c;

endmodule

// File: rtl/if_skid_buf.sv
// One-entry skid buffer for an instruction response that arrives during a decode stall.
// Only compiled when FETCH_SKID_EN is defined.
`ifdef FETCH_SKID_EN
module if_skid_buf
  import cpu_pkg::*;
(
  input  logic            clk,
  input  logic            rst,
  input  logic            push,
  input  logic            pop,
  input  logic            flush,
  input  logic [XLEN-1:0] push_instr,
  input  logic [XLEN-1:0] push_pc,
  output logic            full,
  output logic [XLEN-1:0] instr,
  output logic [XLEN-1:0] pc
);

  always_ff @(posedge clk) begin
    if (rst || flush) begin
      full  <= 1'b0;
      instr <= '0;
      pc    <= '0;
    end else if (push) begin
      full  <= 1'b1;
      instr <= push_instr;
      pc    <= push_pc;
    end else if (pop) begin
      full  <= 1'b0;
    end
  end

endmodule
`endif

// File: rtl/fetch_stage.sv
// Instruction fetch stage: single-outstanding imem requests, IF/ID register, redirect and halt.
// Optional skid buffer for responses arriving under stall: define FETCH_SKID_EN.
module fetch_stage
  import cpu_pkg::*;
#(
  parameter logic [XLEN-1:0] RESET_PC    = RESET_PC_DEF,
  parameter logic [OPW-1:0]  HALT_OPCODE = OP_HALT
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            stall,
  input  logic            redirect,
  input  logic [XLEN-1:0] redirect_pc,
  output logic            imem_req,
  output logic [XLEN-1:0] imem_addr,
  input  logic            imem_ready,
  input  logic [XLEN-1:0] imem_data,
  output logic            if_valid,
  output logic [XLEN-1:0] if_instr,
  output logic [XLEN-1:0] if_pc,
  output logic            halted
);

  fetch_state_t    state, state_d;
  logic [XLEN-1:0] pc, pc_d, pc_inc;
  logic            req_d;
  logic [XLEN-1:0] addr_d;
  logic            if_valid_d;
  logic [XLEN-1:0] if_instr_d, if_pc_d;
  logic            is_halt;
  logic            skid_busy;

  CLA_16bit u_pc_inc (
    .a   (pc),
    .b   (16'h0002),
    .cin (1'b0),
    .sum (pc_inc)
  );

  assign is_halt = (imem_data[15:12] == HALT_OPCODE);

`ifdef FETCH_SKID_EN
  logic            skid_push, skid_pop, skid_full;
  logic [XLEN-1:0] skid_instr, skid_pc;

  if_skid_buf u_skid (
    .clk        (clk),
    .rst        (rst),
    .push       (skid_push),
    .pop        (skid_pop),
    .flush      (redirect),
    .push_instr (imem_data),
    .push_pc    (pc),
    .full       (skid_full),
    .instr      (skid_instr),
    .pc         (skid_pc)
  );

  assign skid_busy = skid_full;
`else
  assign skid_busy = 1'b0;
`endif

  // Next-state, PC and IF/ID update
  always_comb begin
    state_d    = state;
    pc_d       = pc;
    req_d      = 1'b0;
    addr_d     = imem_addr;
    if_valid_d = stall ? if_valid : 1'b0;
    if_instr_d = if_instr;
    if_pc_d    = if_pc;
`ifdef FETCH_SKID_EN
    skid_push  = 1'b0;
    skid_pop   = 1'b0;
    if (skid_full && !stall) begin
      if_valid_d = 1'b1;
      if_instr_d = skid_instr;
      if_pc_d    = skid_pc;
      skid_pop   = 1'b1;
    end
`endif

    case (state)
      ST_FETCH: begin
        if (!(if_valid && stall) && !skid_busy) begin
          req_d   = 1'b1;
          addr_d  = pc;
          state_d = ST_WAIT;
        end
      end
      ST_WAIT: begin
        if (imem_ready) begin
          if (!stall) begin
            if_valid_d = 1'b1;
            if_instr_d = imem_data;
            if_pc_d    = pc;
            pc_d       = pc_inc;
            state_d    = is_halt ? ST_HALT : ST_FETCH;
          end else begin
`ifdef FETCH_SKID_EN
            skid_push = 1'b1;
            pc_d      = pc_inc;
            state_d   = is_halt ? ST_HALT : ST_FETCH;
`else
            state_d   = ST_FETCH;
`endif
          end
        end
      end
      ST_DROP: begin
        if (imem_ready) state_d = ST_FETCH;
      end
      ST_HALT: state_d = ST_HALT;
      default: state_d = ST_FETCH;
    endcase

    // Redirect beats stall and any same-cycle response; a still-pending response must be drained.
    if (redirect) begin
      pc_d       = redirect_pc;
      if_valid_d = 1'b0;
      req_d      = 1'b0;
      addr_d     = imem_addr;
`ifdef FETCH_SKID_EN
      skid_push  = 1'b0;
`endif
      if ((state == ST_WAIT || state == ST_DROP) && !imem_ready) state_d = ST_DROP;
      else                                                        state_d = ST_FETCH;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= ST_FETCH;
      pc        <= RESET_PC;
      imem_req  <= 1'b0;
      imem_addr <= '0;
      if_valid  <= 1'b0;
      if_instr  <= '0;
      if_pc     <= '0;
      halted    <= 1'b0;
    end else begin
      state     <= state_d;
      pc        <= pc_d;
      imem_req  <= req_d;
      imem_addr <= addr_d;
      if_valid  <= if_valid_d;
      if_instr  <= if_instr_d;
      if_pc     <= if_pc_d;
      halted    <= (state_d == ST_HALT);
    end
  end

endmodule

// File: tb/tb_fetch_stage.sv
// Directed self-checking bench for fetch_stage with an address/IF-ID scoreboard.
module tb_fetch_stage;
  import cpu_pkg::*;

  logic        clk;
  logic        rst;
  logic        stall;
  logic        redirect;
  logic [15:0] redirect_pc;
  logic        imem_req;
  logic [15:0] imem_addr;
  logic        imem_ready;
  logic [15:0] imem_data;
  logic        if_valid;
  logic [15:0] if_instr;
  logic [15:0] if_pc;
  logic        halted;

  int n_tests = 0;
  int n_fail  = 0;

  logic [15:0] addr_q[$];
  ifid_t       ifid_q[$];

  fetch_stage dut (
    .clk         (clk),
    .rst         (rst),
    .stall       (stall),
    .redirect    (redirect),
    .redirect_pc (redirect_pc),
    .imem_req    (imem_req),
    .imem_addr   (imem_addr),
    .imem_ready  (imem_ready),
    .imem_data   (imem_data),
    .if_valid    (if_valid),
    .if_instr    (if_instr),
    .if_pc       (if_pc),
    .halted      (halted)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Waits (bounded) for a request and compares its address with the scoreboard head.
  task automatic wait_req();
    bit          seen;
    logic [15:0] exp;
    seen = 1'b0;
    for (int i = 0; i < 40; i++) begin
      if (imem_req === 1'b1) begin
        seen = 1'b1;
        break;
      end
      tick();
    end
    exp = addr_q.pop_front();
    if (!seen) check("req_timeout", 16'd0, 16'd1);
    else       check("imem_addr", imem_addr, exp);
  endtask

  // Memory answers with latency 1 after the request cycle.
  task automatic respond(input logic [15:0] data);
    tick();
    imem_ready = 1'b1;
    imem_data  = data;
    tick();
    imem_ready = 1'b0;
    imem_data  = 16'h0000;
  endtask

  task automatic expect_ifid();
    bit    seen;
    ifid_t exp;
    seen = 1'b0;
    for (int i = 0; i < 40; i++) begin
      if (if_valid === 1'b1) begin
        seen = 1'b1;
        break;
      end
      tick();
    end
    exp = ifid_q.pop_front();
    if (!seen) begin
      check("ifid_timeout", 16'd0, 16'd1);
    end else begin
      check("if_instr", if_instr, exp.instr);
      check("if_pc", if_pc, exp.pc);
    end
  endtask

  task automatic fetch_one(input logic [15:0] addr, input logic [15:0] data);
    addr_q.push_back(addr);
    wait_req();
    ifid_q.push_back('{instr: data, pc: addr});
    respond(data);
    expect_ifid();
  endtask

  // Redirect during the request cycle, then deliver the now-stale response.
  task automatic redirect_in_wait(input logic [15:0] target, input logic [15:0] stale);
    redirect    = 1'b1;
    redirect_pc = target;
    tick();
    redirect    = 1'b0;
    imem_ready  = 1'b1;
    imem_data   = stale;
    tick();
    imem_ready  = 1'b0;
    imem_data   = 16'h0000;
    check("redir_if_valid", 16'(if_valid), 16'd0);
  endtask

  initial begin
    int nreq;
    rst = 1'b1; stall = 1'b0; redirect = 1'b0; redirect_pc = 16'h0000;
    imem_ready = 1'b0; imem_data = 16'h0000;
    tick();
    tick();
    check("rst_imem_req", 16'(imem_req), 16'd0);
    check("rst_if_valid", 16'(if_valid), 16'd0);
    check("rst_if_instr", if_instr, 16'h0000);
    check("rst_if_pc", if_pc, 16'h0000);
    check("rst_halted", 16'(halted), 16'd0);
    rst = 1'b0;

    fetch_one(16'h0000, 16'h1234);
    fetch_one(16'h0002, 16'h5678);

    // Response arrives while decode is stalled
    addr_q.push_back(16'h0004);
    wait_req();
    stall = 1'b1;
    tick();
    imem_ready = 1'b1;
    imem_data  = 16'hABCD;
    tick();
    imem_ready = 1'b0;
    imem_data  = 16'h0000;
    check("stall_resp_not_loaded", 16'(if_valid), 16'd0);
    stall = 1'b0;
`ifdef FETCH_SKID_EN
    ifid_q.push_back('{instr: 16'hABCD, pc: 16'h0004});
    expect_ifid();
`else
    addr_q.push_back(16'h0004);
    wait_req();
    ifid_q.push_back('{instr: 16'hABCD, pc: 16'h0004});
    respond(16'hABCD);
    expect_ifid();
`endif

    addr_q.push_back(16'h0006);
    wait_req();
    redirect_in_wait(16'h0040, 16'hDEAD);
    fetch_one(16'h0040, 16'h1111);

    addr_q.push_back(16'h0042);
    wait_req();
    redirect_in_wait(16'hFFFE, 16'hBEEF);
    fetch_one(16'hFFFE, 16'h2222);

    // PC wraps to 0000; that fetch returns a halt opcode
    fetch_one(16'h0000, 16'hF000);
    check("halted_set", 16'(halted), 16'd1);
    nreq = 0;
    for (int i = 0; i < 20; i++) begin
      tick();
      if (imem_req === 1'b1) nreq++;
    end
    check("halt_no_req", 16'(nreq), 16'd0);
    check("halted_hold", 16'(halted), 16'd1);
    redirect    = 1'b1;
    redirect_pc = 16'h0010;
    tick();
    redirect = 1'b0;
    check("halted_clear", 16'(halted), 16'd0);
    fetch_one(16'h0010, 16'h3333);

    // Stall holds IF/ID and blocks new requests
    stall = 1'b1;
    nreq = 0;
    for (int i = 0; i < 3; i++) begin
      tick();
      if (imem_req === 1'b1) nreq++;
    end
    check("stall_if_valid", 16'(if_valid), 16'd1);
    check("stall_if_instr", if_instr, 16'h3333);
    check("stall_no_req", 16'(nreq), 16'd0);
    stall = 1'b0;

    // Reset during WAIT; the late response must be ignored
    addr_q.push_back(16'h0012);
    wait_req();
    rst = 1'b1;
    tick();
    tick();
    rst        = 1'b0;
    imem_ready = 1'b1;
    imem_data  = 16'hF0F0;
    tick();
    imem_ready = 1'b0;
    imem_data  = 16'h0000;
    check("post_rst_if_valid", 16'(if_valid), 16'd0);
    check("post_rst_halted", 16'(halted), 16'd0);
    fetch_one(16'h0000, 16'h4444);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not complete, observed timeout expected finish");
    $fatal(1);
  end

endmodule
